// File: rtl/pc_fetch_pkg.sv
// Shared widths, PC step and FSM state encoding for the PC/fetch controller.
package pc_fetch_pkg;

  localparam int XLEN    = 64;
  localparam int INSTR_W = 32;
  localparam int PC_STEP = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2,
    S_TRAP  = 2'd3
  } state_t;

  function automatic logic is_misaligned(input logic [1:0] lsb);
    return lsb != 2'b00;
  endfunction

endpackage

// File: rtl/pc_fetch_ctrl_if.sv
// Fetch-side bundle: imem req/ack, decode valid/ready and branch redirect inputs.
interface pc_fetch_ctrl_if #(
  parameter int XLEN    = pc_fetch_pkg::XLEN,
  parameter int INSTR_W = pc_fetch_pkg::INSTR_W
);

  logic               imem_req_o;
  logic [XLEN-1:0]    imem_addr_o;
  logic               imem_ack_i;
  logic [INSTR_W-1:0] imem_data_i;
  logic               instr_valid_o;
  logic [INSTR_W-1:0] instr_o;
  logic [XLEN-1:0]    instr_pc_o;
  logic               dec_ready_i;
  logic               br_taken_i;
  logic [XLEN-1:0]    br_base_i;
  logic [XLEN-1:0]    br_offset_i;
  logic               misalign_o;

  modport master (
    output imem_req_o, imem_addr_o, instr_valid_o, instr_o, instr_pc_o, misalign_o,
    input  imem_ack_i, imem_data_i, dec_ready_i, br_taken_i, br_base_i, br_offset_i
  );

  modport slave (
    input  imem_req_o, imem_addr_o, instr_valid_o, instr_o, instr_pc_o, misalign_o,
    output imem_ack_i, imem_data_i, dec_ready_i, br_taken_i, br_base_i, br_offset_i
  );

endinterface

// File: rtl/pc_target_adder.sv
// Branch target = base + offset (wrapping); flags targets not word aligned.
// Purely combinational, no backpressure.
module pc_target_adder
  import pc_fetch_pkg::*;
#(
  parameter int XLEN = pc_fetch_pkg::XLEN
) (
  input  logic [XLEN-1:0] base,
  input  logic [XLEN-1:0] offset,
  output logic [XLEN-1:0] target,
  output logic            misaligned
);

  assign target     = base + offset;
  assign misaligned = is_misaligned(target[1:0]);

endmodule

// File: rtl/pc_fetch_ctrl.sv
// PC + instruction fetch controller: one fetch (ack) cycle then one hold cycle per instruction.
// Stalls in HOLD while decode is not ready; a taken branch squashes/redirects, misaligned target traps.
module pc_fetch_ctrl #(
  parameter int                      XLEN     = pc_fetch_pkg::XLEN,
  parameter int                      INSTR_W  = pc_fetch_pkg::INSTR_W,
  parameter logic [XLEN-1:0]         RESET_PC = '0
) (
  input  logic           clk_i,
  input  logic           rst_i,
  pc_fetch_ctrl_if.master bus
);

  import pc_fetch_pkg::*;

  localparam logic [XLEN-1:0] PC_INC = XLEN'(PC_STEP);

  state_t             state;
  logic [XLEN-1:0]    pc;
  logic [XLEN-1:0]    pend_pc;
  logic               redirect_pend;
  logic [INSTR_W-1:0] instr_q;
  logic [XLEN-1:0]    instr_pc_q;
  logic               misalign_q;

  logic [XLEN-1:0]    target;
  logic               target_mis;
  logic [XLEN-1:0]    redir_pc;
  logic               redir_mis;

  pc_target_adder #(.XLEN(XLEN)) u_target_adder (
    .base       (bus.br_base_i),
    .offset     (bus.br_offset_i),
    .target     (target),
    .misaligned (target_mis)
  );

  // A branch resolving in the ack cycle is younger than any pending redirect, so it wins.
  assign redir_pc  = bus.br_taken_i ? target : pend_pc;
  assign redir_mis = is_misaligned(redir_pc[1:0]);

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state         <= S_IDLE;
      pc            <= RESET_PC;
      pend_pc       <= '0;
      redirect_pend <= 1'b0;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      misalign_q    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: state <= S_FETCH;

        S_FETCH: begin
          if (bus.imem_ack_i) begin
            if (redirect_pend || bus.br_taken_i) begin
              pc            <= redir_pc;
              redirect_pend <= 1'b0;
              if (redir_mis) begin
                state      <= S_TRAP;
                misalign_q <= 1'b1;
              end
            end else begin
              instr_q    <= bus.imem_data_i;
              instr_pc_q <= pc;
              state      <= S_HOLD;
            end
          end else if (bus.br_taken_i) begin
            // Address must stay stable until ack, so the redirect waits in pend_pc.
            pend_pc       <= target;
            redirect_pend <= 1'b1;
          end
        end

        S_HOLD: begin
          if (bus.br_taken_i) begin
            pc <= target;
            if (target_mis) begin
              state      <= S_TRAP;
              misalign_q <= 1'b1;
            end else begin
              state <= S_FETCH;
            end
          end else if (bus.dec_ready_i) begin
            pc    <= pc + PC_INC;
            state <= S_FETCH;
          end
        end

        S_TRAP: state <= S_TRAP;

        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.imem_req_o    = (state == S_FETCH);
  assign bus.imem_addr_o   = (state == S_IDLE) ? '0 : pc;
  assign bus.instr_valid_o = (state == S_HOLD) && !bus.br_taken_i;
  assign bus.instr_o       = instr_q;
  assign bus.instr_pc_o    = instr_pc_q;
  assign bus.misalign_o    = misalign_q;

endmodule

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
- Program-counter and instruction-fetch controller for the 64-bit CPU datapath.
- Holds the architectural PC and issues fetch requests to instruction memory over a req/ack handshake.
- Hands fetched instructions to decode over a valid/ready handshake.
- Consumes the branch offset from the shift-left-by-one stage, forms the branch target (base + offset) and redirects fetch to it, trapping on misaligned targets.

Parameters:
- XLEN, 64, width of PC, addresses and branch offset.
- INSTR_W, 32, instruction word width.
- RESET_PC, 64'h0, PC value loaded on reset.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_i  input  1  synchronous active-low reset.
- imem_req_o  output  1  fetch request to instruction memory.
- imem_addr_o  output  XLEN  fetch address; stable while imem_req_o is high.
- imem_ack_i  input  1  memory accepted the request and imem_data_i is valid this cycle.
- imem_data_i  input  INSTR_W  fetched instruction word.
- instr_valid_o  output  1  instr_o/instr_pc_o hold an instruction for decode.
- instr_o  output  INSTR_W  instruction word to decode.
- instr_pc_o  output  XLEN  PC of instr_o.
- dec_ready_i  input  1  decode accepts the instruction this cycle.
- br_taken_i  input  1  taken branch/jump resolved this cycle (older instruction).
- br_base_i  input  XLEN  PC of the resolving branch.
- br_offset_i  input  XLEN  branch offset, already shifted left by one.
- misalign_o  output  1  sticky misaligned-target trap flag.

Behaviour:
Reset and output rules:
- Reset occurs when rst_i = 0 at a rising edge.
- Reset values: state = S_IDLE, pc = RESET_PC, instr_o = 0, instr_pc_o = 0, misalign_o = 0, redirect_pend = 0.
- Every output reads 0 while in S_IDLE.
- Reset mid-operation abandons any outstanding request. Memory must tolerate imem_req_o dropping without an ack.

Branch target:
- target = (br_base_i + br_offset_i) mod 2^XLEN, combinational.
- target is misaligned when target[1:0] != 0.

States:
- S_IDLE: next state is S_FETCH on the first edge with rst_i = 1.
- S_FETCH:
  - imem_req_o = 1 and imem_addr_o = pc, both held until imem_ack_i.
  - An ack in the same cycle as the first request is legal.
  - On ack with no redirect pending and br_taken_i = 0: capture instr_o = imem_data_i and instr_pc_o = pc, then go to S_HOLD.
  - On br_taken_i = 1 without ack: latch the target into pend_pc, set redirect_pend, keep the request up.
  - On ack with (redirect_pend or br_taken_i): discard the data. Load pc from pend_pc, or from target if br_taken_i is high this cycle (br_taken_i has priority). Clear redirect_pend and stay in S_FETCH.
  - If the redirect target is misaligned: go to S_TRAP after the ack instead.
- S_HOLD:
  - instr_valid_o = ~br_taken_i. This is the only combinational mask.
  - dec_ready_i = 1 and br_taken_i = 0: pc = pc + 4 (mod 2^XLEN), go to S_FETCH. Back-to-back fetch starts the next cycle.
  - br_taken_i = 1: the held instruction is squashed regardless of dec_ready_i. pc = target, go to S_FETCH, or to S_TRAP if misaligned.
  - Otherwise hold all outputs.
- S_TRAP:
  - misalign_o = 1, imem_req_o = 0, instr_valid_o = 0.
  - pc holds the offending target and is visible on imem_addr_o.
  - Exit only via reset.

Other rules:
- br_taken_i is ignored in S_IDLE and S_TRAP.
- PC increment wraps from 2^XLEN - 4 to 0 with no flag.
- Best-case throughput is 1 instruction per 2 cycles: one fetch cycle with ack, then one hold cycle with ready.

Decomposition:
- Shared package pc_fetch_pkg:
  - XLEN, INSTR_W, PC_STEP = 4.
  - State enum with 2-bit encoding: S_IDLE = 0, S_FETCH = 1, S_HOLD = 2, S_TRAP = 3.
- One sub-module: pc_target_adder.
  - Combinational adder of br_base_i and br_offset_i.
  - Output: target plus a misaligned flag.

Test Plan:
- Reset then release, ack in the same cycle as the request, dec_ready_i held 1 -> imem_addr_o sequence 0x0, 0x4, 0x8. instr_pc_o matches each address, with one instruction every 2 cycles.
- Hold dec_ready_i = 0 for 5 cycles in S_HOLD -> instr_o, instr_pc_o and instr_valid_o stay stable, and no new imem_req_o.
- br_taken_i with br_base_i = 0x100 and br_offset_i = 0x40 during S_FETCH, ack delayed 3 cycles -> imem_addr_o stays at the old pc until ack, the data is discarded, and the next request is to 0x140.
- br_taken_i coincident with dec_ready_i in S_HOLD, target 0x200 -> instr_valid_o = 0 that cycle and the next fetch address is 0x200, not pc + 4.
- Target 0x102 -> misalign_o = 1 sticky and imem_req_o = 0. The flag clears only after rst_i = 0 for one edge, after which fetch restarts at RESET_PC.
- Program pc = 0xFFFF_FFFF_FFFF_FFFC via branch (base 0, offset -4), accept that instruction -> next fetch address 0x0.
